// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fetch_unit
//
// Decoupled instruction-fetch front end for the RV32I cores. Word fetches go
// out on a valid/ready request port to a variable-latency instruction memory.
// Responses come back in order, one per accepted request. Returned words are
// buffered with their PCs in a small FIFO. The decode stage drains the FIFO
// through a valid/ready handshake.
//
// A redirect from execute does the following in one edge:
//   - flushes the FIFO,
//   - retargets fetch,
//   - arms a drop counter, so that responses to requests already in flight
//     are discarded when they return.
//
// Parameters
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2). It also caps
//               the number of outstanding requests, because an issue needs
//               a free FIFO slot reserved for its response.
//   RESET_PC    first fetch address after reset
//
// Ports
//   i_clk             clock, all state on the rising edge
//   i_reset           synchronous active-high reset
//   i_redirect        redirect strobe (taken branch / jump)
//   i_redirect_pc     redirect target; bits [1:0] are ignored
//   o_imem_req_valid  fetch request valid
//   o_imem_req_addr   word-aligned fetch address
//   i_imem_req_ready  memory accepts the request
//   i_imem_rsp_valid  in-order response valid
//   i_imem_rsp_data   instruction word
//   o_insn_valid      FIFO head valid
//   o_insn            instruction at the head
//   o_insn_pc         PC of the head instruction
//   i_insn_ready      consumer takes the head
//   o_fetch_pc        next address to request (debug)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_insn_valid,
    output logic [31:0] o_insn,
    output logic [31:0] o_insn_pc,
    input  logic        i_insn_ready,
    output logic [31:0] o_fetch_pc
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   rsp_pc_reg,   rsp_pc_next;    // PC of the next live response
    logic [CW-1:0] count_reg,    count_next;
    logic [CW-1:0] pend_cnt_reg, pend_cnt_next;  // accepted, not yet answered
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;  // stale responses still to come
    logic [AW-1:0] rd_ptr_reg,   rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg,   wr_ptr_next;

    logic [31:0]   pc_mem_reg   [FIFO_DEPTH];
    logic [31:0]   insn_mem_reg [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [CW:0]   inflight;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_drop;
    logic          push;
    logic          insn_valid;
    logic          pop;
    logic [31:0]   target_pc;

    // Buffered entries plus outstanding requests. Each outstanding request
    // already owns a FIFO slot, so a push can never hit a full FIFO.
    assign inflight  = {1'b0, count_reg} + {1'b0, pend_cnt_reg};
    assign req_valid = !i_reset && !i_redirect && (inflight < DEPTH_W);
    assign req_fire  = req_valid && i_imem_req_ready;

    // A response with nothing outstanding is spurious. It is ignored so that
    // the counters cannot underflow.
    assign rsp_live  = i_imem_rsp_valid && (pend_cnt_reg != '0);
    assign rsp_drop  = rsp_live && (drop_cnt_reg != '0);
    assign push      = rsp_live && !rsp_drop && !i_redirect;

    // Reset and redirect both mask the head, so a pop cannot count in
    // either of those cycles.
    assign insn_valid = (count_reg != '0) && !i_redirect && !i_reset;
    assign pop        = insn_valid && i_insn_ready;

    // The low two address bits are dropped by masking the whole word.
    assign target_pc  = i_redirect_pc & 32'hFFFF_FFFC;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        count_next    = count_reg;
        pend_cnt_next = pend_cnt_reg;
        drop_cnt_next = drop_cnt_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;

        if (i_redirect) begin
            // Everything still outstanding after this edge is stale.
            // This includes requests that were already doomed, so this
            // assignment overrides any earlier drop count.
            // Back-to-back redirects therefore keep an exact tally.
            fetch_pc_next = target_pc;
            rsp_pc_next   = target_pc;
            count_next    = '0;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            pend_cnt_next = pend_cnt_reg - CW'(rsp_live);
            drop_cnt_next = pend_cnt_reg - CW'(rsp_live);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if (push) begin
                rsp_pc_next = rsp_pc_reg + 32'd4;
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
            pend_cnt_next = pend_cnt_reg + CW'(req_fire) - CW'(rsp_live);
            count_next    = count_reg + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            count_reg    <= '0;
            pend_cnt_reg <= '0;
            drop_cnt_reg <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            count_reg    <= count_next;
            pend_cnt_reg <= pend_cnt_next;
            drop_cnt_reg <= drop_cnt_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. It is cleared on reset so that the head reads as zero.
    // It is not cleared on a redirect, because there the count alone hides
    // the stale contents.
    // ------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0] entry_we;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_reg[i]   <= '0;
                insn_mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (entry_we[i]) begin
                    pc_mem_reg[i]   <= rsp_pc_reg;
                    insn_mem_reg[i] <= i_imem_rsp_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_imem_req_valid = req_valid;
    assign o_imem_req_addr  = fetch_pc_reg;
    assign o_fetch_pc       = fetch_pc_reg;
    assign o_insn_valid     = insn_valid;
    assign o_insn           = insn_mem_reg[rd_ptr_reg];
    assign o_insn_pc        = pc_mem_reg[rd_ptr_reg];

endmodule
